// File: rtl/riscv_md_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package riscv_md_pkg;

  typedef enum logic [3:0] {
    MD_MUL    = 4'b0000,
    MD_MULH   = 4'b0001,
    MD_MULHSU = 4'b0010,
    MD_MULHU  = 4'b0011,
    MD_DIV    = 4'b0100,
    MD_DIVU   = 4'b0101,
    MD_REM    = 4'b0110,
    MD_REMU   = 4'b0111,
    MD_NONE   = 4'b1111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } md_state_e;

  localparam logic [31:0] MD_DIV0_Q  = '1;
  localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. Shift-add multiply and restoring divide share one
// 64-bit {hi,lo} shift register and one 33-bit adder/subtractor.
module mul_div_unit
  import riscv_md_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      mul_div_op_in,
  input  logic [XLEN-1:0] op_a_in,
  input  logic [XLEN-1:0] op_b_in,
  input  logic            kill,
  output logic            busy,
  output logic            ACK_out,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(ITER);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;

  md_op_e          in_op;
  logic            in_valid, in_div, in_rem, a_signed, b_signed, sign_a, sign_b;
  logic            in_neg, div0, ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_val;

  logic [XLEN:0]     add_a, add_b, sum;
  logic              cin;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   rem_fix, fix_val;

  // Decode the incoming op: signedness, magnitudes, final sign and the fast-path divide cases.
  always_comb begin
    in_op    = md_op_e'(mul_div_op_in);
    in_valid = ~mul_div_op_in[3];
    in_div   = mul_div_op_in[2];
    in_rem   = mul_div_op_in[1];
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (in_op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MD_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    sign_a   = a_signed & op_a_in[XLEN-1];
    sign_b   = b_signed & op_b_in[XLEN-1];
    a_mag    = sign_a ? -op_a_in : op_a_in;
    b_mag    = sign_b ? -op_b_in : op_b_in;
    // Remainder follows the dividend; everything else follows the product/quotient sign.
    in_neg   = (in_div & in_rem) ? sign_a : (sign_a ^ sign_b);
    div0     = in_div & (op_b_in == '0);
    ovf      = in_div & b_signed & (op_a_in == MD_INT_MIN) & (op_b_in == '1);
    fast     = div0 | ovf;
    if (div0) fast_val = in_rem ? op_a_in : MD_DIV0_Q;
    else      fast_val = in_rem ? '0 : MD_INT_MIN;
  end

  // Shared adder: accumulate for multiply, trial-subtract the divisor for divide.
  always_comb begin
    if (op_q[2]) begin
      add_a = {hi_q, lo_q[XLEN-1]};
      add_b = ~{1'b0, opnd_q};
      cin   = 1'b1;
    end else begin
      add_a = {1'b0, hi_q};
      add_b = lo_q[0] ? {1'b0, opnd_q} : '0;
      cin   = 1'b0;
    end
    sum = add_a + add_b + {{XLEN{1'b0}}, cin};
  end

  // Sign fix-up and result selection; low word of -{hi,lo} doubles as the negated quotient.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    rem_fix  = neg_q ? -hi_q : hi_q;
    if (!op_q[2]) fix_val = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else          fix_val = op_q[1] ? rem_fix : prod_fix[XLEN-1:0];
  end

  // Next-state logic: capture in IDLE or on the ACK cycle, iterate, fix up, acknowledge.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (in_valid) begin
            op_d = mul_div_op_in[2:0];
            if (fast) begin
              state_d  = DONE;
              result_d = fast_val;
            end else begin
              state_d = CALC;
              count_d = CW'(ITER - 1);
              neg_d   = in_neg;
              hi_d    = '0;
              lo_d    = in_div ? a_mag : b_mag;
              opnd_d  = in_div ? b_mag : a_mag;
            end
          end
        end
        CALC: begin
          count_d = count_q - 1'b1;
          if (op_q[2]) begin
            // Restore (keep the shifted remainder) when the trial subtract went negative.
            hi_d = sum[XLEN] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : sum[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~sum[XLEN]};
          end else begin
            {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
          end
          if (count_q == '0) state_d = FIX;
        end
        FIX: begin
          result_d = fix_val;
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  assign busy    = (state_q == CALC) || (state_q == FIX);
  assign ACK_out = (state_q == DONE);
  assign result  = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model plus directed vectors.
module tb_mul_div_unit;

  logic        clk, rst, kill, busy, ACK_out;
  logic [3:0]  op;
  logic [31:0] a, b, result;

  int n_checks = 0;
  int n_pass   = 0;

  mul_div_unit #(.XLEN(32), .ITER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mul_div_op_in(op),
    .op_a_in      (a),
    .op_b_in      (b),
    .kill         (kill),
    .busy         (busy),
    .ACK_out      (ACK_out),
    .result       (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: returns {fast_path, result}.
  function automatic logic [32:0] model_calc(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    logic signed [63:0] sx, sy, sp;
    logic [63:0]        ux, uy, up;
    logic               f;
    logic [31:0]        r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    f  = 1'b0;
    r  = '0;
    case (o)
      4'd0: begin sp = sx * sy;          r = sp[31:0];  end
      4'd1: begin sp = sx * sy;          r = sp[63:32]; end
      4'd2: begin sp = sx * $signed(uy); r = sp[63:32]; end
      4'd3: begin up = ux * uy;          r = up[63:32]; end
      4'd4: begin
        if (y == 0) begin f = 1'b1; r = 32'hFFFF_FFFF; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin f = 1'b1; r = x; end
        else r = $signed(x) / $signed(y);
      end
      4'd5: begin
        if (y == 0) begin f = 1'b1; r = 32'hFFFF_FFFF; end
        else r = x / y;
      end
      4'd6: begin
        if (y == 0) begin f = 1'b1; r = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin f = 1'b1; r = 0; end
        else r = $signed(x) % $signed(y);
      end
      4'd7: begin
        if (y == 0) begin f = 1'b1; r = x; end
        else r = x % y;
      end
      default: ;
    endcase
    return {f, r};
  endfunction

  // Timeline model: after a capture the ACK lands in cycle 1 (fast) or 34, busy before it.
  logic        m_active, exp_ack, exp_busy, m_free, m_fast;
  int          m_cyc, m_lat;
  logic [31:0] m_pend, exp_res, m_r;

  initial begin
    m_active = 1'b0;
    m_cyc    = 0;
    m_lat    = 0;
    m_pend   = '0;
    exp_res  = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0;
        exp_res  = '0;
      end else begin
        m_free = !m_active || (m_cyc == m_lat);
        if (m_active) begin
          if (m_cyc == m_lat) m_active = 1'b0;
          else m_cyc++;
        end
        if (kill) begin
          m_active = 1'b0;
        end else if (m_free && !op[3]) begin
          {m_fast, m_r} = model_calc(op, a, b);
          m_active = 1'b1;
          m_cyc    = 1;
          m_lat    = m_fast ? 1 : 34;
          m_pend   = m_r;
        end
        if (m_active && m_cyc == m_lat) exp_res = m_pend;
      end
    end
  end

  assign exp_ack  = m_active && (m_cyc == m_lat);
  assign exp_busy = m_active && (m_cyc < m_lat);

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc ack", {31'b0, ACK_out}, {31'b0, exp_ack});
      chk("cyc busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("cyc result", result, exp_res);
    end
  end

  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
    int  cyc, bc;
    bit  got;
    @(posedge clk);
    #1 op = o; a = x; b = y;
    @(posedge clk);
    #1 op = 4'hF;
    cyc = 0;
    bc  = 0;
    got = 0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
      if (ACK_out) got = 1;
    end
    chk({name, " latency"}, cyc, lat);
    chk({name, " busy cycles"}, bc, lat - 1);
    chk({name, " result"}, result, exp);
  endtask

  initial begin
    rst  = 1'b1;
    kill = 1'b0;
    op   = 4'hF;
    a    = '0;
    b    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset ack", {31'b0, ACK_out}, 32'd0);
    chk("reset result", result, 32'd0);
    #2 rst = 1'b0;

    run_op("MUL", 4'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("MULH", 4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("MULHU", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("MULHSU", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("DIV", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("REM", 4'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("DIVU", 4'd5, 32'd100, 32'd7, 32'd14, 34);
    run_op("REMU", 4'd7, 32'd100, 32'd7, 32'd2, 34);

    // Kill in CALC cycle 10: no ACK, result keeps 2.
    @(posedge clk);
    #1 op = 4'd4; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 op = 4'hF;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("kill result", result, 32'd2);

    // Kill coinciding with a capture request: nothing starts.
    @(posedge clk);
    #1 op = 4'd0; a = 32'd3; b = 32'd3; kill = 1'b1;
    @(posedge clk);
    #1 op = 4'hF; kill = 1'b0;
    @(negedge clk);
    chk("kill+capture busy", {31'b0, busy}, 32'd0);
    chk("kill+capture ack", {31'b0, ACK_out}, 32'd0);

    run_op("DIVU by 0", 4'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REM by 0", 4'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("DIVU 2", 4'd5, 32'd100, 32'd7, 32'd14, 34);

    // Asynchronous reset in the middle of CALC.
    @(posedge clk);
    #1 op = 4'd4; a = 32'd77; b = 32'd5;
    @(posedge clk);
    #1 op = 4'hF;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", {31'b0, busy}, 32'd0);
    chk("async rst ack", {31'b0, ACK_out}, 32'd0);
    chk("async rst result", result, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    run_op("MUL after rst", 4'd0, 32'hFFFF_FFFE, 32'd9, 32'hFFFF_FFEE, 34);

    @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
